// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit MIPS datapath: byte-wise instruction fetch,
// then decode / execute / memory / writeback sequencing with Moore-decoded control lines.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// FETCH1-4 | read one instruction byte each, PC += 1, load IR byte 3..0
// DECODE   | read register file, precompute branch target into ALUOut
// MEMADR   | compute load/store address A + imm
// LBRD     | read data memory at ALUOut
// LBWR     | write loaded byte into rt
// SBWR     | write B to data memory at ALUOut
// RTYPEEX  | ALU op on A, B selected by funct
// RTYPEWR  | write ALUOut into rd
// BEQEX    | compare A - B, load PC from ALUOut when zero
// JEX      | load PC with jump target
// ADDIEX   | A + imm
// ADDIWR   | write ALUOut into rt
module mips_controller (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  output logic       o_memread,
  output logic       o_memwrite,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic       o_iord,
  output logic [3:0] o_irwrite,
  output logic       o_memtoreg,
  output logic       o_regdst,
  output logic       o_regwrite,
  output logic       o_pcen,
  output logic [1:0] o_pcsource,
  output logic [2:0] o_alucontrol
);

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13
  } state_t;

  // ADDIWR takes the last code point; 15 stays unused and recovers via default.
  localparam logic [3:0] S_ADDIWR = 4'd14;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_pcwrite;
  logic       w_branch;
  logic [2:0] w_funct_alu;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_FETCH1;
    else         r_state <= w_next;
  end

  always_comb begin
    w_funct_alu = ALU_ADD;
    case (i_funct)
      6'b100000: w_funct_alu = ALU_ADD;
      6'b100010: w_funct_alu = ALU_SUB;
      6'b100100: w_funct_alu = ALU_AND;
      6'b100101: w_funct_alu = ALU_OR;
      6'b101010: w_funct_alu = ALU_SLT;
      default:   w_funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    w_next       = S_FETCH1;
    o_memread    = 1'b0;
    o_memwrite   = 1'b0;
    o_alusrca    = 1'b0;
    o_alusrcb    = 2'b00;
    o_iord       = 1'b0;
    o_irwrite    = 4'b0000;
    o_memtoreg   = 1'b0;
    o_regdst     = 1'b0;
    o_regwrite   = 1'b0;
    o_pcsource   = 2'b00;
    o_alucontrol = ALU_ADD;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;

    case (r_state)
      S_FETCH1: begin
        o_memread = 1'b1;
        o_alusrcb = 2'b01;
        o_irwrite = 4'b1000;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH2;
      end
      S_FETCH2: begin
        o_memread = 1'b1;
        o_alusrcb = 2'b01;
        o_irwrite = 4'b0100;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH3;
      end
      S_FETCH3: begin
        o_memread = 1'b1;
        o_alusrcb = 2'b01;
        o_irwrite = 4'b0010;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH4;
      end
      S_FETCH4: begin
        o_memread = 1'b1;
        o_alusrcb = 2'b01;
        o_irwrite = 4'b0001;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        o_alusrcb = 2'b11;
        case (i_op)
          OP_LB, OP_SB: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_J:         w_next = S_JEX;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_next = S_FETCH1;
        endcase
      end
      S_MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        // op is stable here, so the load/store split can wait until now
        w_next    = (i_op == OP_SB) ? S_SBWR : S_LBRD;
      end
      S_LBRD: begin
        o_memread = 1'b1;
        o_iord    = 1'b1;
        w_next    = S_LBWR;
      end
      S_LBWR: begin
        o_regwrite = 1'b1;
        o_memtoreg = 1'b1;
        w_next     = S_FETCH1;
      end
      S_SBWR: begin
        o_memwrite = 1'b1;
        o_iord     = 1'b1;
        w_next     = S_FETCH1;
      end
      S_RTYPEEX: begin
        o_alusrca    = 1'b1;
        o_alucontrol = w_funct_alu;
        w_next       = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        o_regwrite = 1'b1;
        o_regdst   = 1'b1;
        w_next     = S_FETCH1;
      end
      S_BEQEX: begin
        o_alusrca    = 1'b1;
        o_alucontrol = ALU_SUB;
        o_pcsource   = 2'b01;
        w_branch     = 1'b1;
        w_next       = S_FETCH1;
      end
      S_JEX: begin
        o_pcsource = 2'b10;
        w_pcwrite  = 1'b1;
        w_next     = S_FETCH1;
      end
      S_ADDIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        w_next    = S_ADDIWR;
      end
      S_ADDIWR: begin
        o_regwrite = 1'b1;
        w_next     = S_FETCH1;
      end
      default: begin
        w_next = S_FETCH1;
      end
    endcase
  end

  assign o_pcen = w_pcwrite | (w_branch & i_zero);

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench for mips_controller: per-cycle expected control vectors are queued by
// the driver from an instruction-level model and compared by an independent monitor.
module tb_mips_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] irwrite;
  logic [2:0] alucontrol;

  mips_controller dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_op         (op),
    .i_funct      (funct),
    .i_zero       (zero),
    .o_memread    (memread),
    .o_memwrite   (memwrite),
    .o_alusrca    (alusrca),
    .o_alusrcb    (alusrcb),
    .o_iord       (iord),
    .o_irwrite    (irwrite),
    .o_memtoreg   (memtoreg),
    .o_regdst     (regdst),
    .o_regwrite   (regwrite),
    .o_pcen       (pcen),
    .o_pcsource   (pcsource),
    .o_alucontrol (alucontrol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] v;
    int          instr;
    int          step;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   instr_no = 0;

  logic [18:0] act;
  assign act = {memread, memwrite, alusrca, alusrcb, iord, irwrite,
                memtoreg, regdst, regwrite, pcen, pcsource, alucontrol};

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int instr_len(input logic [5:0] o);
    case (o)
      6'b100000:                       return 8;
      6'b101000, 6'b000000, 6'b001000: return 7;
      6'b000100, 6'b000010:            return 6;
      default:                         return 5;
    endcase
  endfunction

  // Expected control vector for cycle k of an instruction (k=0 is FETCH1).
  function automatic logic [18:0] expect_vec(input logic [5:0] o, input logic [5:0] f,
                                             input logic z, input int k);
    logic mr = 0, mw = 0, sa = 0, io = 0, mtr = 0, rd = 0, rw = 0, pe = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [3:0] ir = 4'b0000;
    logic [2:0] ac = 3'b010;
    int e = k - 5;
    if (k < 4) begin
      mr = 1; sb = 2'b01; pe = 1;
      ir = 4'b1000 >> k;
    end else if (k == 4) begin
      sb = 2'b11;
    end else begin
      case (o)
        6'b100000: case (e)
                     0: begin sa = 1; sb = 2'b10; end
                     1: begin mr = 1; io = 1; end
                     default: begin rw = 1; mtr = 1; end
                   endcase
        6'b101000: if (e == 0) begin sa = 1; sb = 2'b10; end
                   else begin mw = 1; io = 1; end
        6'b000000: if (e == 0) begin sa = 1; ac = funct_alu(f); end
                   else begin rw = 1; rd = 1; end
        6'b000100: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
        6'b000010: begin ps = 2'b10; pe = 1; end
        6'b001000: if (e == 0) begin sa = 1; sb = 2'b10; end
                   else rw = 1;
        default: ;
      endcase
    end
    return {mr, mw, sa, sb, io, ir, mtr, rd, rw, pe, ps, ac};
  endfunction

  // zmode: 0 force zero low, 1 force high, 2 random every cycle.
  // abort_at >= 0 asserts reset asynchronously during that cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           input int abort_at);
    exp_t x;
    int n = instr_len(o);
    instr_no++;
    for (int k = 0; k < n; k++) begin
      op    = o;
      funct = f;
      zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (k == abort_at) begin
        reset = 1'b1;
        x.v = expect_vec(o, f, zero, 0);
        x.instr = instr_no; x.step = -1;
        q.push_back(x);
        @(posedge clk); #1;
        return;
      end
      x.v = expect_vec(o, f, zero, k);
      x.instr = instr_no; x.step = k;
      q.push_back(x);
      @(posedge clk); #1;
    end
  endtask

  // Hold reset for additional cycles; release is in the first cycle of the next instruction.
  task automatic hold_reset(input int cycles);
    exp_t x;
    for (int i = 0; i < cycles; i++) begin
      reset = 1'b1;
      zero  = 1'($urandom_range(0, 1));
      op    = 6'($urandom);
      x.v = expect_vec(6'b111111, 6'd0, zero, 0);
      x.instr = instr_no; x.step = -1;
      q.push_back(x);
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (act !== x.v) begin
          errors++;
          $display("FAIL ctrl instr=%0d step=%0d op=%b funct=%b zero=%b actual=%b required=%b",
                   x.instr, x.step, op, funct, zero, act, x.v);
        end
      end
    end
  end

  logic [5:0] ops_tbl [6];
  logic [5:0] fn_tbl  [5];

  initial begin : driver
    logic [5:0] o, f;
    ops_tbl = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    fn_tbl  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
    @(posedge clk); #1;
    hold_reset(2);

    run_instr(6'b100000, 6'd0, 2, 5);       // reset lands in MEMADR
    hold_reset(1);
    run_instr(6'b100000, 6'd0, 2, -1);
    run_instr(6'b000000, 6'b101010, 2, -1);
    run_instr(6'b000000, 6'b111111, 2, -1);
    run_instr(6'b000100, 6'd0, 1, -1);
    run_instr(6'b000100, 6'd0, 0, -1);
    run_instr(6'b000010, 6'd0, 2, -1);
    run_instr(6'b111111, 6'd0, 2, -1);
    run_instr(6'b101000, 6'd0, 2, -1);
    run_instr(6'b001000, 6'd0, 2, -1);

    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 7) < 6) o = ops_tbl[$urandom_range(0, 5)];
      else                          o = 6'($urandom);
      if ($urandom_range(0, 3) != 0) f = fn_tbl[$urandom_range(0, 4)];
      else                           f = 6'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        run_instr(o, f, 2, int'($urandom_range(0, 7)));
        hold_reset(int'($urandom_range(0, 2)));
      end else begin
        run_instr(o, f, 2, -1);
      end
    end

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_controller.md
# mips_controller

Multicycle control FSM for the 8-bit MIPS datapath. It reads the latched opcode and funct fields plus the ALU zero flag, and drives every datapath control line plus the memory read and write strobes. It fetches each 32-bit instruction as four byte reads, then sequences decode, execute, memory and writeback. It sits beside the datapath in the top-level processor and is the only source of its control inputs.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces the FETCH1 state.
- op  in  6  opcode, instr[31:26].
- funct  in  6  function field, instr[5:0].
- zero  in  1  datapath ALU-result-is-zero flag.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- alusrca  out  1  1 selects register A; 0 selects PC.
- alusrcb  out  2  00 register B, 01 constant 1, 10 instr[7:0], 11 instr[5:0]<<2.
- iord  out  1  1 selects ALUOut as memory address; 0 selects PC.
- irwrite  out  4  one-hot byte enable for the instruction register; bit3 loads instr[31:24].
- memtoreg  out  1  1 writes memory data to the register file; 0 writes ALUOut.
- regdst  out  1  1 writes to rd (instr[13:11]); 0 writes to rt (instr[18:16]).
- regwrite  out  1  register file write enable.
- pcen  out  1  PC load enable.
- pcsource  out  2  00 ALU result, 01 ALUOut, 10 jump target (instr[5:0]<<2).
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.

## Operation
- Opcodes:
  - LB 100000
  - SB 101000
  - RTYPE 000000
  - BEQ 000100
  - J 000010
  - ADDI 001000
- Funct decode, used only in RTYPEEX:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other funct gives add (010).
- Outputs not listed for a state are 0. alusrcb, pcsource and alucontrol default to 00, 00 and 010.
- Fetch states:
  - FETCH1..FETCH4: memread=1, iord=0, alusrca=0, alusrcb=01, pcsource=00, pcwrite=1.
  - irwrite is 1000, 0100, 0010, 0001 respectively.
  - Transitions are FETCH1 → FETCH2 → FETCH3 → FETCH4 → DECODE.
- DECODE:
  - Outputs: alusrca=0, alusrcb=11.
  - Next state by op: LB or SB → MEMADR; RTYPE → RTYPEEX; BEQ → BEQEX; J → JEX; ADDI → ADDIEX.
  - Any other op → FETCH1, executed as a no-op.
- MEMADR: alusrca=1, alusrcb=10. Next is LBRD for LB, SBWR for SB.
- LBRD: memread=1, iord=1, then → LBWR.
- LBWR: regwrite=1, memtoreg=1, regdst=0, then → FETCH1.
- SBWR: memwrite=1, iord=1, then → FETCH1.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct, then → RTYPEWR.
- RTYPEWR: regwrite=1, regdst=1, memtoreg=0, then → FETCH1.
- BEQEX: alusrca=1, alusrcb=00, alucontrol=110, pcsource=01, branch=1, then → FETCH1.
- JEX: pcsource=10, pcwrite=1, then → FETCH1.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010, then → ADDIWR.
- ADDIWR: regwrite=1, regdst=0, memtoreg=0, then → FETCH1.
- pcen = pcwrite | (branch & zero).

## Timing
- Moore outputs decoded from the registered state.
- Exceptions:
  - pcen depends combinationally on zero.
  - alucontrol depends combinationally on funct in RTYPEEX.
- Cycles per instruction, FETCH1 to the next FETCH1:
  - LB 8
  - SB, RTYPE, ADDI 7
  - BEQ, J 6
  - Unrecognised op 5
- Reset:
  - Asserting reset at any time, including mid-instruction, immediately forces FETCH1.
  - While reset is held, outputs show FETCH1 values: memread=1, irwrite=1000, alusrcb=01, pcen=1, all others 0/default.
  - Fetch resumes on the first rising edge after reset deasserts; that edge advances to FETCH2.
- op and funct are sampled only in DECODE and the execute states. The instruction register is stable from DECODE until the next FETCH1.
- The state register uses a binary encoding of at least 4 bits. Any unreachable encoding recovers to FETCH1 on the next edge.

## Test plan
- Reset mid-MEMADR:
  - Stimulus: assert reset while in MEMADR.
  - Required: outputs immediately show FETCH1 values (irwrite=1000, memread=1).
  - After release, irwrite steps 0100, 0010, 0001 on the next three edges.
- LB:
  - Stimulus: op=100000.
  - Required: 8-cycle sequence; memread=1 with iord=1 in the cycle after MEMADR; next cycle regwrite=1, memtoreg=1, regdst=0.
- RTYPE:
  - Stimulus: op=000000, funct=101010.
  - Required: alucontrol=111 in RTYPEEX.
  - Next cycle: regwrite=1, regdst=1, memtoreg=0.
  - Repeat with funct=111111; required alucontrol=010.
- BEQ:
  - Stimulus: op=000100, zero=1, then zero=0.
  - Required: pcen=1 with pcsource=01 for zero=1; pcen=0 for zero=0.
  - Both cases return to FETCH1 after 6 cycles.
- J and unrecognised op:
  - Stimulus: op=000010.
  - Required: JEX has pcen=1, pcsource=10.
  - Stimulus: op=111111.
  - Required: DECODE returns to FETCH1, with no regwrite and no memwrite at any point.
- SB and ADDI:
  - Stimulus: op=101000.
  - Required: memwrite=1 with iord=1 in SBWR.
  - Stimulus: op=001000.
  - Required: ADDIEX has alusrcb=10, alucontrol=010; ADDIWR has regwrite=1, regdst=0.
